mem_port_arbiter: RTL and testbench



---
 rtl/riscv_bus_pkg.sv | 19 +
 rtl/arb_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions: arbiter state/grant encodings and datapath widths.
package riscv_bus_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selector: data priority with a fetch anti-starvation override.
module arb_pick
    import riscv_bus_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic [1:0] exclude,     // bit 0 masks fetch, bit 1 masks data (grant encoding order)
    input  logic       streak_max,
    output logic       grant_valid,
    output grant_t     grant_id
);

    logic if_ok;
    logic d_ok;

    // Data wins unless fetch is waiting and the data streak has hit its limit.
    always_comb begin
        if_ok       = if_req & ~exclude[0];
        d_ok        = d_req  & ~exclude[1];
        grant_valid = if_ok | d_ok;
        grant_id    = (d_ok && !(if_ok && streak_max)) ? GRANT_D : GRANT_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory with fixed read latency.
module mem_port_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = XLEN,
    parameter int unsigned ADDR_WIDTH  = ADDR_W,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MAX_STREAK  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STREAK_TOP = 4'(MAX_STREAK);

    arb_state_t state;
    grant_t     gnt;
    logic [3:0] wait_cnt;
    logic [3:0] streak;
    logic [1:0] exclude;
    logic       at_max;
    logic       pick_valid;
    grant_t     pick_id;

    // In RESP the port being served still holds req, so it is masked out of arbitration.
    always_comb begin
        exclude = '0;
        if (state == S_RESP) begin
            exclude = (gnt == GRANT_D) ? 2'b10 : 2'b01;
        end
        at_max = (streak == STREAK_TOP);
    end

    arb_pick u_pick (
        .if_req      (if_req),
        .d_req       (d_req),
        .exclude     (exclude),
        .streak_max  (at_max),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    // Access sequencer: grant, strobe, wait out the latency, then pulse ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            gnt       <= GRANT_IF;
            wait_cnt  <= '0;
            streak    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                // RESP shares the grant path with IDLE so back-to-back accesses skip IDLE.
                S_IDLE, S_RESP: begin
                    if (pick_valid) begin
                        gnt    <= pick_id;
                        mem_en <= 1'b1;
                        state  <= S_ACCESS;
                        if (pick_id == GRANT_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (!if_req) begin
                                streak <= '0;
                            end else if (!at_max) begin
                                streak <= streak + 4'd1;
                            end
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            streak    <= '0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_RESP;
                        if (gnt == GRANT_IF) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            d_rdata <= mem_we ? '0 : mem_rdata;
                            d_ready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A uses WAIT_CYCLES=1/MAX_STREAK=4, instance B uses 3/1.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_reset, a_if_req, a_if_ready, a_d_req, a_d_we, a_d_ready;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_reset, b_if_req, b_if_ready, b_d_req, b_d_we, b_d_ready;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [31:0] b_p1, b_p2;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'h0051_3093 : {a[15:0], ~a[15:0]};
    endfunction

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(1), .MAX_STREAK(4)) dut_a (
        .clk(clk), .reset(a_reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdata(a_d_rdata), .d_ready(a_d_ready),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WAIT_CYCLES(3), .MAX_STREAK(1)) dut_b (
        .clk(clk), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ready(b_d_ready),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory models: data valid exactly WAIT_CYCLES cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
        a_mem_rdata <= a_mem_en ? mem_fn(a_mem_addr) : 32'hDEAD_BEEF;
        b_p1        <= b_mem_en ? mem_fn(b_mem_addr) : 32'hDEAD_BEEF;
        b_p2        <= b_p1;
        b_mem_rdata <= b_p2;
    end

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        a_if_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
        a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
        b_if_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_if_addr = '0; b_d_addr = '0; b_d_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_mem_en, a_mem_we, a_if_ready, a_d_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_a_ctrl: got %b expected 0000", {a_mem_en, a_mem_we, a_if_ready, a_d_ready});
        end
        checks++;
        if ({a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata} !== 128'h0) begin
            errors++; $display("FAIL reset_a_data: got %h expected 0", {a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata});
        end
        checks++;
        if ({b_mem_en, b_mem_we, b_if_ready, b_d_ready} !== 4'b0000) begin
            errors++; $display("FAIL reset_b_ctrl: got %b expected 0000", {b_mem_en, b_mem_we, b_if_ready, b_d_ready});
        end
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        a_if_addr = 32'h0000_0040; a_if_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (a_mem_en !== (c == 1)) begin
                errors++; $display("FAIL fetch_mem_en c%0d: got %b expected %b", c, a_mem_en, (c == 1));
            end
            checks++;
            if (a_if_ready !== (c == 3)) begin
                errors++; $display("FAIL fetch_if_ready c%0d: got %b expected %b", c, a_if_ready, (c == 3));
            end
            checks++;
            if (a_d_ready !== 1'b0) begin
                errors++; $display("FAIL fetch_d_ready c%0d: got %b expected 0", c, a_d_ready);
            end
            if (c == 1) begin
                checks++;
                if ({a_mem_we, a_mem_addr} !== {1'b0, 32'h0000_0040}) begin
                    errors++; $display("FAIL fetch_addr: got we=%b addr=%h expected we=0 addr=00000040", a_mem_we, a_mem_addr);
                end
            end
            if (c >= 3) begin
                checks++;
                if (a_if_rdata !== 32'h0051_3093) begin
                    errors++; $display("FAIL fetch_rdata c%0d: got %h expected 00513093", c, a_if_rdata);
                end
            end
            if (c == 3) a_if_req = 1'b0;
        end
    endtask

    task automatic test_collision();
        a_if_addr = 32'h0000_0080; a_if_req = 1'b1;
        a_d_addr = 32'h1000_0024; a_d_we = 1'b0; a_d_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (a_mem_en !== (c == 1 || c == 4)) begin
                errors++; $display("FAIL coll_mem_en c%0d: got %b expected %b", c, a_mem_en, (c == 1 || c == 4));
            end
            checks++;
            if ({a_d_ready, a_if_ready} !== {(c == 3), (c == 6)}) begin
                errors++; $display("FAIL coll_ready c%0d: got d=%b if=%b expected d=%b if=%b",
                                   c, a_d_ready, a_if_ready, (c == 3), (c == 6));
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (a_mem_addr !== ((c == 1) ? 32'h1000_0024 : 32'h0000_0080)) begin
                    errors++; $display("FAIL coll_addr c%0d: got %h expected %h", c, a_mem_addr,
                                       (c == 1) ? 32'h1000_0024 : 32'h0000_0080);
                end
            end
            if (c == 3) begin
                checks++;
                if (a_d_rdata !== mem_fn(32'h1000_0024)) begin
                    errors++; $display("FAIL coll_d_rdata: got %h expected %h", a_d_rdata, mem_fn(32'h1000_0024));
                end
                a_d_req = 1'b0;
            end
            if (c == 6) begin
                checks++;
                if (a_if_rdata !== mem_fn(32'h0000_0080)) begin
                    errors++; $display("FAIL coll_if_rdata: got %h expected %h", a_if_rdata, mem_fn(32'h0000_0080));
                end
                a_if_req = 1'b0;
            end
        end
    endtask

    // Both ports held: the served port is masked in RESP, so grants alternate D, IF, D, IF.
    task automatic test_starvation();
        logic [31:0] exp_addr;
        a_if_addr = 32'h0000_0084; a_d_addr = 32'h1000_0030; a_d_we = 1'b0;
        a_if_req = 1'b1; a_d_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (a_mem_en !== (c == 1 || c == 4 || c == 7 || c == 10)) begin
                errors++; $display("FAIL starve_mem_en c%0d: got %b", c, a_mem_en);
            end
            checks++;
            if ({a_d_ready, a_if_ready} !== {(c == 3 || c == 9), (c == 6 || c == 12)}) begin
                errors++; $display("FAIL starve_ready c%0d: got d=%b if=%b", c, a_d_ready, a_if_ready);
            end
            if (c == 1 || c == 4 || c == 7 || c == 10) begin
                exp_addr = (c == 1 || c == 7) ? 32'h1000_0030 : 32'h0000_0084;
                checks++;
                if (a_mem_addr !== exp_addr) begin
                    errors++; $display("FAIL starve_grant c%0d: got addr %h expected %h", c, a_mem_addr, exp_addr);
                end
            end
            if (c == 11) begin
                a_if_req = 1'b0; a_d_req = 1'b0;
            end
        end
    endtask

    task automatic test_write();
        a_d_we = 1'b1; a_d_addr = 32'h1000_0028; a_d_wdata = 32'h0000_00A5; a_d_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (a_mem_en !== (c == 1)) begin
                errors++; $display("FAIL wr_mem_en c%0d: got %b expected %b", c, a_mem_en, (c == 1));
            end
            checks++;
            if (a_d_ready !== (c == 3)) begin
                errors++; $display("FAIL wr_d_ready c%0d: got %b expected %b", c, a_d_ready, (c == 3));
            end
            if (c <= 2) begin
                checks++;
                if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 32'h1000_0028, 32'h0000_00A5}) begin
                    errors++; $display("FAIL wr_bus c%0d: got we=%b addr=%h wdata=%h expected 1 10000028 000000a5",
                                       c, a_mem_we, a_mem_addr, a_mem_wdata);
                end
            end
            if (c == 1) begin
                a_d_wdata = 32'h0000_00FF; a_d_addr = 32'h0;
            end
            if (c == 3) begin
                checks++;
                if (a_d_rdata !== 32'h0) begin
                    errors++; $display("FAIL wr_d_rdata: got %h expected 0", a_d_rdata);
                end
                a_d_req = 1'b0; a_d_we = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        a_if_addr = 32'h0000_0040; a_if_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1 || c == 4) begin
                checks++;
                if (a_mem_en !== 1'b1) begin
                    errors++; $display("FAIL rstmid_mem_en c%0d: got %b expected 1", c, a_mem_en);
                end
            end
            if (c == 2) a_reset = 1'b1;
            if (c == 3) begin
                checks++;
                if ({a_mem_en, a_mem_we, a_if_ready, a_d_ready} !== 4'b0000) begin
                    errors++; $display("FAIL rstmid_ctrl: got %b expected 0000", {a_mem_en, a_mem_we, a_if_ready, a_d_ready});
                end
                checks++;
                if ({a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata} !== 128'h0) begin
                    errors++; $display("FAIL rstmid_data: got %h expected 0", {a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata});
                end
                a_reset = 1'b0;
            end
            if (c >= 4) begin
                checks++;
                if (a_if_ready !== (c == 6)) begin
                    errors++; $display("FAIL rstmid_if_ready c%0d: got %b expected %b", c, a_if_ready, (c == 6));
                end
            end
            if (c == 6) begin
                checks++;
                if (a_if_rdata !== 32'h0051_3093) begin
                    errors++; $display("FAIL rstmid_rdata: got %h expected 00513093", a_if_rdata);
                end
                a_if_req = 1'b0;
            end
        end
    endtask

    task automatic test_latency_sweep();
        b_if_addr = 32'h0000_0100; b_if_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (b_mem_en !== (c == 1)) begin
                errors++; $display("FAIL lat_mem_en c%0d: got %b expected %b", c, b_mem_en, (c == 1));
            end
            checks++;
            if (b_if_ready !== (c == 5)) begin
                errors++; $display("FAIL lat_if_ready c%0d: got %b expected %b", c, b_if_ready, (c == 5));
            end
            if (c == 5) begin
                checks++;
                if (b_if_rdata !== mem_fn(32'h0000_0100)) begin
                    errors++; $display("FAIL lat_rdata: got %h expected %h", b_if_rdata, mem_fn(32'h0000_0100));
                end
                b_if_req = 1'b0;
            end
        end
    endtask

    // MAX_STREAK=1: a data grant taken while fetch was requesting forces fetch to win the next tie.
    task automatic test_streak_limit();
        logic        exp_en;
        logic [31:0] exp_addr;
        b_if_addr = 32'h0000_0104; b_d_addr = 32'h1000_0040; b_d_we = 1'b0;
        b_if_req = 1'b1; b_d_req = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            @(negedge clk);
            exp_en = (c == 1 || c == 6 || c == 11 || c == 17 || c == 22);
            checks++;
            if (b_mem_en !== exp_en) begin
                errors++; $display("FAIL streak_mem_en c%0d: got %b expected %b", c, b_mem_en, exp_en);
            end
            checks++;
            if ({b_d_ready, b_if_ready} !== {(c == 5 || c == 15 || c == 26), (c == 10 || c == 21)}) begin
                errors++; $display("FAIL streak_ready c%0d: got d=%b if=%b", c, b_d_ready, b_if_ready);
            end
            if (exp_en) begin
                exp_addr = (c == 6) ? 32'h0000_0104 : (c == 17) ? 32'h0000_0108 : 32'h1000_0040;
                checks++;
                if (b_mem_addr !== exp_addr) begin
                    errors++; $display("FAIL streak_grant c%0d: got addr %h expected %h", c, b_mem_addr, exp_addr);
                end
            end
            case (c)
                11: b_if_req = 1'b0;
                15: b_d_req = 1'b0;
                16: begin
                    b_if_addr = 32'h0000_0108; b_if_req = 1'b1; b_d_req = 1'b1;
                end
                22: b_if_req = 1'b0;
                26: b_d_req = 1'b0;
                default: ;
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_write();
        test_reset_mid();
        test_latency_sweep();
        test_streak_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
